// File: rtl/mips32_pipe_core.sv
// mips32_pipe_core: single-clock 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset core
// with full EX forwarding, load-use stall, EX branch flush and HLT/illegal stop.
module mips32_pipe_core #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int IMEM_AW = 10,
  parameter int DMEM_AW = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               retire_valid,
  output logic               halted,
  output logic               illegal_op
);

  localparam int RIW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [5:0] {
    OP_ADD   = 6'h00,
    OP_SUB   = 6'h01,
    OP_AND   = 6'h02,
    OP_OR    = 6'h03,
    OP_SLT   = 6'h04,
    OP_MUL   = 6'h05,
    OP_LW    = 6'h08,
    OP_SW    = 6'h09,
    OP_ADDI  = 6'h0A,
    OP_SUBI  = 6'h0B,
    OP_SLTI  = 6'h0C,
    OP_BNEQZ = 6'h0D,
    OP_BEQZ  = 6'h0E,
    OP_HLT   = 6'h3F
  } opcode_e;

  typedef struct packed {
    logic               valid;
    logic [31:0]        instr;
    logic [IMEM_AW-1:0] pc;
  } ifid_t;

  typedef struct packed {
    logic               valid;
    logic [5:0]         op;
    logic [RIW-1:0]     rs;
    logic [RIW-1:0]     rt;
    logic [RIW-1:0]     dest;
    logic               wen;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [15:0]        imm;
    logic [IMEM_AW-1:0] pc;
  } idex_t;

  typedef struct packed {
    logic              valid;
    logic [5:0]        op;
    logic [RIW-1:0]    dest;
    logic              wen;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] sdata;
  } exmem_t;

  typedef struct packed {
    logic              valid;
    logic [5:0]        op;
    logic [RIW-1:0]    dest;
    logic              wen;
    logic [DATA_W-1:0] res;
  } memwb_t;

  function automatic logic is_rtype(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
  endfunction

  function automatic logic writes_rt(input logic [5:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_SLTI, OP_LW};
  endfunction

  function automatic logic reads_rs(input logic [5:0] op);
    return is_rtype(op) || writes_rt(op) || (op inside {OP_SW, OP_BNEQZ, OP_BEQZ});
  endfunction

  function automatic logic reads_rt(input logic [5:0] op);
    return is_rtype(op) || (op == OP_SW);
  endfunction

  // HLT and every undefined opcode stop fetch and, on retiring, stop the core.
  function automatic logic is_stop(input logic [5:0] op);
    return !(reads_rs(op));
  endfunction

  logic [IMEM_AW-1:0] pc;
  logic               fetch_stop;
  ifid_t              ifid;
  idex_t              idex, id_next;
  exmem_t             exmem, ex_next;
  memwb_t             memwb, mem_next;
  logic [DATA_W-1:0]  rf [NREGS];

  // ---------------- ID: decode, write-through register read, hazards
  logic [5:0]        id_op;
  logic [RIW-1:0]    id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_a, id_b;
  logic              wb_wen, ld_use, id_stop;

  assign id_op  = ifid.instr[31:26];
  assign id_rs  = ifid.instr[21 +: RIW];
  assign id_rt  = ifid.instr[16 +: RIW];
  assign id_rd  = ifid.instr[11 +: RIW];
  assign wb_wen = memwb.valid && memwb.wen && !halted;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    id_a = rf[id_rs];
    id_b = rf[id_rt];
    if (wb_wen && (memwb.dest == id_rs)) id_a = memwb.res;
    if (wb_wen && (memwb.dest == id_rt)) id_b = memwb.res;
    if (id_rs == '0) id_a = '0;
    if (id_rt == '0) id_b = '0;
  end

  always_comb begin
    id_next       = '0;
    id_next.valid = ifid.valid;
    id_next.op    = id_op;
    id_next.rs    = id_rs;
    id_next.rt    = id_rt;
    id_next.a     = id_a;
    id_next.b     = id_b;
    id_next.imm   = ifid.instr[15:0];
    id_next.pc    = ifid.pc;
    if (is_rtype(id_op)) begin
      id_next.dest = id_rd;
      id_next.wen  = (id_rd != '0);
    end else if (writes_rt(id_op)) begin
      id_next.dest = id_rt;
      id_next.wen  = (id_rt != '0);
    end
  end

  assign ld_use = idex.valid && (idex.op == OP_LW) && idex.wen && ifid.valid &&
                  ((reads_rs(id_op) && (id_rs == idex.dest)) ||
                   (reads_rt(id_op) && (id_rt == idex.dest)));
  assign id_stop = ifid.valid && is_stop(id_op);

  // ---------------- EX: forwarding (EX/MEM beats MEM/WB), ALU, branch resolve
  logic [DATA_W-1:0]  ex_a, ex_b, ex_imm, ex_res;
  logic [IMEM_AW-1:0] br_target;
  logic               br_taken;

  always_comb begin
    ex_a = idex.a;
    ex_b = idex.b;
    if (exmem.valid && exmem.wen && (exmem.dest == idex.rs))      ex_a = exmem.res;
    else if (memwb.valid && memwb.wen && (memwb.dest == idex.rs)) ex_a = memwb.res;
    if (exmem.valid && exmem.wen && (exmem.dest == idex.rt))      ex_b = exmem.res;
    else if (memwb.valid && memwb.wen && (memwb.dest == idex.rt)) ex_b = memwb.res;
  end

  assign ex_imm = DATA_W'(signed'(idex.imm));

  always_comb begin
    ex_res = '0;
    case (idex.op)
      OP_ADD:               ex_res = ex_a + ex_b;
      OP_SUB:               ex_res = ex_a - ex_b;
      OP_AND:               ex_res = ex_a & ex_b;
      OP_OR:                ex_res = ex_a | ex_b;
      OP_SLT:               ex_res = DATA_W'(ex_a < ex_b);
      OP_MUL:               ex_res = ex_a * ex_b;
      OP_ADDI, OP_LW, OP_SW: ex_res = ex_a + ex_imm;
      OP_SUBI:              ex_res = ex_a - ex_imm;
      OP_SLTI:              ex_res = DATA_W'(ex_a < ex_imm);
      default:              ex_res = '0;
    endcase
  end

  assign br_taken  = idex.valid && (((idex.op == OP_BEQZ)  && (ex_a == '0)) ||
                                    ((idex.op == OP_BNEQZ) && (ex_a != '0)));
  assign br_target = idex.pc + IMEM_AW'(1) + IMEM_AW'(signed'(idex.imm));

  always_comb begin
    ex_next       = '0;
    ex_next.valid = idex.valid;
    ex_next.op    = idex.op;
    ex_next.dest  = idex.dest;
    ex_next.wen   = idex.wen;
    ex_next.res   = ex_res;
    ex_next.sdata = ex_b;
  end

  // ---------------- MEM
  assign dmem_addr  = DMEM_AW'(exmem.res);
  assign dmem_wdata = exmem.sdata;
  assign dmem_we    = exmem.valid && (exmem.op == OP_SW) && !halted;

  always_comb begin
    mem_next       = '0;
    mem_next.valid = exmem.valid;
    mem_next.op    = exmem.op;
    mem_next.dest  = exmem.dest;
    mem_next.wen   = exmem.wen;
    mem_next.res   = (exmem.op == OP_LW) ? dmem_rdata : exmem.res;
  end

  // ---------------- WB / status
  assign imem_addr    = pc;
  assign retire_valid = memwb.valid && !halted;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      fetch_stop <= 1'b0;
      ifid       <= '0;
      idex       <= '0;
      exmem      <= '0;
      memwb      <= '0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else if (!halted) begin
      if (memwb.valid && is_stop(memwb.op)) halted <= 1'b1;
      if (memwb.valid && is_stop(memwb.op) && (memwb.op != OP_HLT)) illegal_op <= 1'b1;
      memwb <= mem_next;
      exmem <= ex_next;
      if (br_taken) begin
        // Taken branch squashes both younger stages and overrides any stall.
        pc   <= br_target;
        ifid <= '0;
        idex <= '0;
      end else if (ld_use) begin
        idex <= '0;
      end else begin
        idex <= id_next;
        if (id_stop) fetch_stop <= 1'b1;
        if (fetch_stop || id_stop) begin
          ifid <= '0;
        end else begin
          ifid.valid <= 1'b1;
          ifid.instr <= imem_rdata;
          ifid.pc    <= pc;
          pc         <= pc + IMEM_AW'(1);
        end
      end
    end
  end

  // NOTE: the register file is reset because programs rely on every register starting at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_wen) begin
      rf[memwb.dest] <= memwb.res;
    end
  end

endmodule

// File: tb/tb_mips32_pipe_core.sv
// Directed bench for mips32_pipe_core: hand-assembled programs, cycle and
// retire counts, register and data-memory results, mid-run reset.
module tb_mips32_pipe_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  imem_addr, dmem_addr, imem_addr16, dmem_addr16;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, imem_rdata16;
  logic [15:0] dmem_wdata16, dmem_rdata16;
  logic        dmem_we, retire_valid, halted, illegal_op;
  logic        dmem_we16, retire_valid16, halted16, illegal_op16;

  logic [31:0] imem   [1024];
  logic [31:0] dmem   [1024];
  logic [15:0] dmem16 [1024];
  logic        mem_clear = 1'b0;
  logic [31:0] dmem_fill = '0;

  assign imem_rdata   = imem[imem_addr];
  assign imem_rdata16 = imem[imem_addr16];
  assign dmem_rdata   = dmem[dmem_addr];
  assign dmem_rdata16 = dmem16[dmem_addr16];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) begin
        dmem[i]   <= dmem_fill;
        dmem16[i] <= '0;
      end
    end else begin
      if (dmem_we)   dmem[dmem_addr]     <= dmem_wdata;
      if (dmem_we16) dmem16[dmem_addr16] <= dmem_wdata16;
    end
  end

  mips32_pipe_core dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata),
    .retire_valid(retire_valid), .halted(halted), .illegal_op(illegal_op)
  );

  mips32_pipe_core #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr16), .imem_rdata(imem_rdata16),
    .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16), .dmem_we(dmem_we16),
    .dmem_rdata(dmem_rdata16),
    .retire_valid(retire_valid16), .halted(halted16), .illegal_op(illegal_op16)
  );

  int checks = 0;
  int failures = 0;
  int cycles, retires, writes;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic new_prog();
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
  endtask

  task automatic put(input int a, input logic [31:0] w);
    imem[a] = w;
  endtask

  // Holds reset over two edges (clearing data memory), releases just after a rising edge.
  task automatic reset_release();
    rst_n = 1'b0;
    mem_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_clear = 1'b0;
    rst_n = 1'b1;
    cycles = 0;
    retires = 0;
    writes = 0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic step();
    @(negedge clk);
    if (retire_valid) retires++;
    if (dmem_we) begin
      writes++;
      wr_addr = dmem_addr;
      wr_data = dmem_wdata;
    end
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic run_to_halt();
    while (halted !== 1'b1 && cycles < 200) step();
  endtask

  logic [9:0] frozen_pc;

  initial begin
    // ---- 1: back-to-back forwarding, reset state
    new_prog();
    put(0, 32'h2801000A); put(1, 32'h28020014); put(2, 32'h28030019);
    put(3, 32'h00222000); put(4, 32'h00832800); put(5, 32'hFC000000);
    reset_release();
    check("rst_pc", imem_addr, 0);
    check("rst_halted", halted, 0);
    check("rst_retire", retire_valid, 0);
    check("rst_we", dmem_we, 0);
    check("rst_illegal", illegal_op, 0);
    run_to_halt();
    check("fwd_cycles", cycles, 10);
    check("fwd_retires", retires, 6);
    check("fwd_r1", dut.rf[1], 10);
    check("fwd_r2", dut.rf[2], 20);
    check("fwd_r3", dut.rf[3], 25);
    check("fwd_r4", dut.rf[4], 30);
    check("fwd_r5", dut.rf[5], 55);
    frozen_pc = imem_addr;
    check("halt_pc", frozen_pc, 6);
    repeat (3) step();
    check("halt_hold", halted, 1);
    check("halt_pc_frozen", imem_addr, 6);
    check("halt_no_retire", retire_valid, 0);
    check("halt_retires_after", retires, 6);

    // ---- 2: load-use stall
    new_prog();
    put(0, 32'h28010007); put(1, 32'h24010005); put(2, 32'h20020005);
    put(3, 32'h00421800); put(4, 32'hFC000000);
    reset_release();
    run_to_halt();
    check("lu_cycles_one_stall", cycles, 10);
    check("lu_writes", writes, 1);
    check("lu_wr_addr", wr_addr, 5);
    check("lu_wr_data", wr_data, 7);
    check("lu_dmem5", dmem[5], 7);
    check("lu_r2", dut.rf[2], 7);
    check("lu_r3", dut.rf[3], 14);

    // ---- 3: branch loop
    new_prog();
    put(0, 32'h28010003); put(1, 32'h2C210001); put(2, 32'h3420FFFE);
    put(3, 32'h28060009); put(4, 32'hFC000000);
    reset_release();
    run_to_halt();
    check("br_cycles", cycles, 17);
    check("br_retires", retires, 9);
    check("br_r1", dut.rf[1], 0);
    check("br_r6", dut.rf[6], 9);
    check("br_illegal", illegal_op, 0);

    // ---- 4: R0 protection and DATA_W wrap
    new_prog();
    put(0, 32'h28000005); put(1, 32'h00003800); put(2, 32'h2801FFFF);
    put(3, 32'h28220001); put(4, 32'hFC000000);
    reset_release();
    run_to_halt();
    check("r0_cycles", cycles, 9);
    check("r0_r0", dut.rf[0], 0);
    check("r0_r7", dut.rf[7], 0);
    check("w32_r1", dut.rf[1], 32'hFFFF_FFFF);
    check("w32_r2", dut.rf[2], 0);
    check("w16_halted", halted16, 1);
    check("w16_r1", dut16.rf[1], 16'hFFFF);
    check("w16_r2", dut16.rf[2], 0);

    // ---- 5: illegal opcode at address 2
    new_prog();
    put(0, 32'h28010001); put(1, 32'h28020002); put(2, 32'h80030005);
    put(3, 32'h28040004); put(4, 32'hFC000000);
    reset_release();
    run_to_halt();
    check("ill_cycles", cycles, 7);
    check("ill_flag", illegal_op, 1);
    check("ill_halted", halted, 1);
    check("ill_retires", retires, 3);
    check("ill_r1", dut.rf[1], 1);
    check("ill_r2", dut.rf[2], 2);
    check("ill_r3_unchanged", dut.rf[3], 0);
    check("ill_r4_unchanged", dut.rf[4], 0);
    check("ill_w16_flag", illegal_op16, 1);

    // ---- 6: reset asserted while SW is in EX
    new_prog();
    put(0, 32'h28010007); put(1, 32'h28080003); put(2, 32'h28090004);
    put(3, 32'h24010005); put(4, 32'h20020005); put(5, 32'h00421800);
    put(6, 32'hFC000000);
    dmem_fill = 32'hDEAD_BEEF;
    reset_release();
    repeat (5) step();
    check("mid_retire_before", retire_valid, 1);
    check("mid_r1_before", dut.rf[1], 7);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", imem_addr, 0);
    check("mid_rst_retire", retire_valid, 0);
    check("mid_rst_we", dmem_we, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_r1", dut.rf[1], 0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_write", dmem[5], 32'hDEAD_BEEF);
    reset_release();
    check("mid_restart_pc", imem_addr, 0);
    run_to_halt();
    check("mid_rerun_cycles", cycles, 12);
    check("mid_rerun_writes", writes, 1);
    check("mid_rerun_dmem5", dmem[5], 7);
    check("mid_rerun_r3", dut.rf[3], 14);
    check("mid_rerun_r9", dut.rf[9], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
